// File: rtl/stabilizer_basis_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stabilizer_basis_gen : emits the initial N-qubit Z/X-basis stabilizer tableau,
// one single-literal row per valid/ready handshake.      rev 1.0
// ----------------------------------------------------------------------------
module stabilizer_basis_gen #(
  parameter int NUM_QUBIT = 3,
  parameter int ROW_W     = $clog2(NUM_QUBIT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [NUM_QUBIT-1:0] init_bits_i,
  input  logic                 out_ready_i,
  output logic                 out_valid_o,
  output logic [1:0]           literals_o [0:NUM_QUBIT-1],
  output logic                 phase_o,
  output logic [ROW_W-1:0]     row_idx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]       LIT_I    = 2'b00;
  localparam logic [1:0]       LIT_Z    = 2'b01;
  localparam logic [1:0]       LIT_X    = 2'b10;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_QUBIT - 1);

  state_t                 state_q;
  logic [NUM_QUBIT-1:0]   bits_q;
  logic [ROW_W-1:0]       row_idx_d;

  assign row_idx_d = row_idx_o + ROW_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bits_q      <= '0;
      out_valid_o <= 1'b0;
      phase_o     <= 1'b0;
      row_idx_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      for (int j = 0; j < NUM_QUBIT; j++)
        literals_o[j] <= (j == 0) ? LIT_Z : LIT_I;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            bits_q      <= init_bits_i;
            phase_o     <= init_bits_i[0];
            row_idx_o   <= '0;
            out_valid_o <= 1'b1;
            busy_o      <= 1'b1;
            state_q     <= S_EMIT;
            for (int j = 0; j < NUM_QUBIT; j++)
              literals_o[j] <= (j == 0) ? (mode_i ? LIT_X : LIT_Z) : LIT_I;
          end
        end
        S_EMIT: begin
          if (out_ready_i) begin
            if (row_idx_o == LAST_ROW) begin
              out_valid_o <= 1'b0;
              done_o      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              // Basis choice lives in the literal vector; shifting it walks the diagonal.
              for (int j = 0; j < NUM_QUBIT; j++)
                literals_o[j] <= literals_o[(j + NUM_QUBIT - 1) % NUM_QUBIT];
              phase_o   <= bits_q[row_idx_d];
              row_idx_o <= row_idx_d;
            end
          end
        end
        S_DONE: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
